// File: rtl/ascon_p_iter.sv
// ascon_p_iter: iterative Ascon permutation core (p12 / p8 / p6).
//   A request (in_valid & in_ready) loads the 320-bit state and a round count.
//   The core then applies UNROLL rounds per cycle, raises out_valid, and holds
//   the result on s_out until out_ready is seen.
// Parameters:
//   UNROLL  rounds per clock, 1 or 2
//   BW      lane width, must be 64
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready high only when idle)
//   rounds               0:12, 1:8, 2:6, 3:12 rounds; sampled on acceptance
//   s_in                 input state {x0,x1,x2,x3,x4}, x0 in MSBs
//   out_valid / out_ready result handshake
//   s_out                permuted state, same lane order (the state register)
//   abort                only when ASCON_P_ITER_ABORT_EN is defined: drops the
//                        permutation in progress and returns to idle
module ascon_p_iter #(
  parameter int UNROLL = 1,
  parameter int BW     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      rounds,
  input  logic [5*BW-1:0] s_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*BW-1:0] s_out
`ifdef ASCON_P_ITER_ABORT_EN
  ,
  input  logic            abort
`endif
);

  generate
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_p_iter: UNROLL must be 1 or 2");
    end
    if (BW != 64) begin : g_bad_bw
      $error("ascon_p_iter: BW must be 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t            fsm;
  logic [3:0]      r;
  logic [3:0]      r_start;
  logic [5*BW-1:0] st;
  logic [5*BW-1:0] st_nxt;
  logic            last_step;

  function automatic logic [BW-1:0] ror(input logic [BW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (BW - n));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box, linear layer.
  function automatic logic [5*BW-1:0] round_fn(input logic [5*BW-1:0] s,
                                               input logic [3:0]      ri);
    logic [BW-1:0] x0, x1, x2, x3, x4;
    logic [BW-1:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {{(BW-8){1'b0}}, 4'hF - ri, ri};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  always_comb begin
    st_nxt = st;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      st_nxt = round_fn(st_nxt, r + 4'(i));
    end
  end

  always_comb begin
    case (rounds)
      2'd1:    r_start = 4'd4;
      2'd2:    r_start = 4'd6;
      default: r_start = 4'd0;
    endcase
  end

  // Round counts are all even, so with UNROLL=2 the final step covers r=10,11.
  assign last_step = (r == 4'(12 - UNROLL));
  assign s_out     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      st        <= '0;
      r         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
`ifdef ASCON_P_ITER_ABORT_EN
      if (abort && fsm != IDLE) begin
        fsm       <= IDLE;
        st        <= '0;
        r         <= '0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end else
`endif
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st       <= s_in;
            r        <= r_start;
            fsm      <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          st <= st_nxt;
          r  <= r + 4'(UNROLL);
          if (last_step) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
